// File: rtl/command_bus_arbiter_pkg.sv
// ============================================================================
// command_bus_arbiter_pkg - shared state encoding and sizing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package command_bus_arbiter_pkg;

  localparam int c_cmd_w_default = 204;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } arb_state_t;

  // Width of a counter that runs 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/command_bus_arbiter_rr_arbiter.sv
// ============================================================================
// command_bus_arbiter_rr_arbiter - combinational round-robin pick
// Rev 1.0
// ============================================================================
`default_nettype none

module command_bus_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_hi_idx;
  logic             w_hi_any;
  logic [IDX_W-1:0] w_lo_idx;
  logic             w_lo_any;

  // Lowest valid at/after the pointer wins; otherwise wrap to the lowest valid overall.
  always_comb begin
    w_hi_idx = '0;
    w_hi_any = 1'b0;
    w_lo_idx = '0;
    w_lo_any = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_valid[j]) begin
        w_lo_idx = IDX_W'(j);
        w_lo_any = 1'b1;
        if (IDX_W'(j) >= i_ptr) begin
          w_hi_idx = IDX_W'(j);
          w_hi_any = 1'b1;
        end
      end
    end
  end

  assign o_any   = w_lo_any;
  assign o_idx   = w_hi_any ? w_hi_idx : w_lo_idx;
  assign o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/command_bus_arbiter.sv
// ============================================================================
// command_bus_arbiter - round-robin sharing of the configuration command bus
// Rev 1.0
// ============================================================================
`default_nettype none

module command_bus_arbiter
  import command_bus_arbiter_pkg::*;
#(
  parameter int CMD_W      = c_cmd_w_default,
  parameter int NUM_REQ    = 2,
  parameter int RD_TIMEOUT = 255,
  parameter int MIN_GAP    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ*CMD_W-1:0] iv_req_cmd,
  input  logic [NUM_REQ-1:0]       iv_req_valid,
  input  logic [NUM_REQ-1:0]       iv_req_is_rd,
  output logic [NUM_REQ-1:0]       ov_req_ready,
  output logic [CMD_W-1:0]         ov_rd_ack,
  output logic [NUM_REQ-1:0]       ov_rd_ack_valid,
  output logic [NUM_REQ-1:0]       ov_rd_timeout,
  output logic [CMD_W-1:0]         ov_wr_command,
  output logic                     o_wr_command_wr,
  output logic [CMD_W-1:0]         ov_rd_command,
  output logic                     o_rd_command_wr,
  input  logic [CMD_W-1:0]         iv_rd_command_ack,
  input  logic                     i_rd_command_ack_wr,
  output logic                     o_stray_ack_pulse
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_tmr_w = cnt_width(RD_TIMEOUT);
  localparam int c_gap_w = cnt_width(MIN_GAP);

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(RD_TIMEOUT - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [NUM_REQ-1:0] c_one_hot0 = NUM_REQ'(1);

  arb_state_t         r_state;
  logic [c_idx_w-1:0] r_ptr;
  logic [c_idx_w-1:0] r_owner;
  logic               r_is_rd;
  logic [c_tmr_w-1:0] r_timer;
  logic [c_gap_w-1:0] r_gap_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [c_idx_w-1:0] w_idx;
  logic               w_any;
  logic [CMD_W-1:0]   w_slot [NUM_REQ];
  arb_state_t         w_post_state;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    assign w_slot[k] = iv_req_cmd[k*CMD_W +: CMD_W];
  end

  // With no forced gap the bus returns straight to IDLE after a command completes.
  assign w_post_state = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;

  command_bus_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_rr_arbiter (
    .i_valid (iv_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= ST_IDLE;
      r_ptr             <= '0;
      r_owner           <= '0;
      r_is_rd           <= 1'b0;
      r_timer           <= '0;
      r_gap_cnt         <= '0;
      ov_req_ready      <= '0;
      ov_rd_ack         <= '0;
      ov_rd_ack_valid   <= '0;
      ov_rd_timeout     <= '0;
      ov_wr_command     <= '0;
      o_wr_command_wr   <= 1'b0;
      ov_rd_command     <= '0;
      o_rd_command_wr   <= 1'b0;
      o_stray_ack_pulse <= 1'b0;
    end else begin
      ov_req_ready      <= '0;
      ov_rd_ack_valid   <= '0;
      ov_rd_timeout     <= '0;
      o_wr_command_wr   <= 1'b0;
      o_rd_command_wr   <= 1'b0;
      o_stray_ack_pulse <= i_rd_command_ack_wr && (r_state != ST_WAIT_ACK);

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner      <= w_idx;
            r_is_rd      <= iv_req_is_rd[w_idx];
            r_ptr        <= (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
            ov_req_ready <= w_grant;
            if (iv_req_is_rd[w_idx]) begin
              ov_rd_command   <= w_slot[w_idx];
              o_rd_command_wr <= 1'b1;
            end else begin
              ov_wr_command   <= w_slot[w_idx];
              o_wr_command_wr <= 1'b1;
            end
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_timer   <= '0;
          r_gap_cnt <= '0;
          r_state   <= r_is_rd ? ST_WAIT_ACK : w_post_state;
        end
        ST_WAIT_ACK: begin
          // An ack arriving on the final timeout cycle still completes the read.
          if (i_rd_command_ack_wr) begin
            ov_rd_ack       <= iv_rd_command_ack;
            ov_rd_ack_valid <= c_one_hot0 << r_owner;
            r_state         <= w_post_state;
          end else if (r_timer == c_tmr_last) begin
            ov_rd_timeout <= c_one_hot0 << r_owner;
            r_state       <= w_post_state;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
